// File: rtl/rc4_key_tester.sv
// RC4 decrypt/test engine: S init, KSA, PRGA on a 3-byte key, plaintext charset check.
// Define RC4_EARLY_ABORT_EN to stop at the first byte outside a-z/space.
module rc4_key_tester #(
  parameter int MSG_LEN = 32,
  parameter int MSG_AW  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic [23:0]       key_in,
  output logic              finish_decrypt,
  output logic              valid,
  output logic              busy,
  output logic [7:0]        s_addr,
  output logic [7:0]        s_wdata,
  output logic              s_wren,
  input  logic [7:0]        s_rdata,
  output logic [MSG_AW-1:0] rom_addr,
  input  logic [7:0]        rom_rdata,
  output logic [MSG_AW-1:0] d_addr,
  output logic [7:0]        d_wdata,
  output logic              d_wren
);

  localparam logic [3:0] S_LOAD = 4'd0;
  localparam logic [3:0] S_INIT = 4'd1;
  localparam logic [3:0] S_KRI  = 4'd2;
  localparam logic [3:0] S_KRJ  = 4'd3;
  localparam logic [3:0] S_KWI  = 4'd4;
  localparam logic [3:0] S_KWJ  = 4'd5;
  localparam logic [3:0] S_PRI  = 4'd6;
  localparam logic [3:0] S_PRJ  = 4'd7;
  localparam logic [3:0] S_PWI  = 4'd8;
  localparam logic [3:0] S_PWJ  = 4'd9;
  localparam logic [3:0] S_PRF  = 4'd10;
  localparam logic [3:0] S_PWD  = 4'd11;
  localparam logic [3:0] S_DONE = 4'd12;

  localparam logic [MSG_AW-1:0] LAST = MSG_AW'(MSG_LEN - 1);

  logic [3:0]        r_state;
  logic              r_ph;
  logic [23:0]       r_key;
  logic [7:0]        r_i;
  logic [7:0]        r_j;
  logic [7:0]        r_si;
  logic [7:0]        r_sj;
  logic [1:0]        r_kidx;
  logic [MSG_AW-1:0] r_k;
  logic [7:0]        r_d;
  logic              r_bad;
  logic              r_busy;
  logic              r_finish;
  logic              r_valid;

  logic [7:0] w_kbyte;
  logic       w_ok;
  logic       w_bad;
  logic       w_last;

  always_comb begin
    case (r_kidx)
      2'd0:    w_kbyte = r_key[23:16];
      2'd1:    w_kbyte = r_key[15:8];
      default: w_kbyte = r_key[7:0];
    endcase
  end

  assign w_ok   = (r_d == 8'h20) | ((r_d >= 8'h61) & (r_d <= 8'h7A));
  assign w_bad  = r_bad | ~w_ok;
`ifdef RC4_EARLY_ABORT_EN
  assign w_last = (r_k == LAST) | ~w_ok;
`else
  assign w_last = (r_k == LAST);
`endif

  assign finish_decrypt = r_finish;
  assign valid          = r_valid;
  assign busy           = r_busy;

  // Memory ports are decoded from state so a restart silences them at once.
  always_comb begin
    s_addr   = 8'd0;
    s_wdata  = 8'd0;
    s_wren   = 1'b0;
    rom_addr = '0;
    d_addr   = '0;
    d_wdata  = 8'd0;
    d_wren   = 1'b0;
    case (r_state)
      S_INIT: begin
        s_addr  = r_i;
        s_wdata = r_i;
        s_wren  = 1'b1;
      end
      S_KRI, S_PRI: s_addr = r_i;
      S_KRJ, S_PRJ: s_addr = r_j;
      S_KWI, S_PWI: begin
        s_addr  = r_i;
        s_wdata = r_sj;
        s_wren  = 1'b1;
      end
      S_KWJ, S_PWJ: begin
        s_addr  = r_j;
        s_wdata = r_si;
        s_wren  = 1'b1;
      end
      S_PRF: begin
        s_addr   = r_si + r_sj;
        rom_addr = r_k;
      end
      S_PWD: begin
        d_addr  = r_k;
        d_wdata = r_d;
        d_wren  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_LOAD;
      r_ph     <= 1'b0;
      r_key    <= 24'd0;
      r_i      <= 8'd0;
      r_j      <= 8'd0;
      r_si     <= 8'd0;
      r_sj     <= 8'd0;
      r_kidx   <= 2'd0;
      r_k      <= '0;
      r_d      <= 8'd0;
      r_bad    <= 1'b0;
      r_busy   <= 1'b0;
      r_finish <= 1'b0;
      r_valid  <= 1'b0;
    end else if (restart) begin
      r_state  <= S_LOAD;
      r_ph     <= 1'b0;
      r_finish <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_key   <= key_in;
          r_busy  <= 1'b1;
          r_bad   <= 1'b0;
          r_i     <= 8'd0;
          r_state <= S_INIT;
        end
        S_INIT: begin
          r_i <= r_i + 8'd1;
          if (r_i == 8'hFF) begin
            r_j     <= 8'd0;
            r_kidx  <= 2'd0;
            r_state <= S_KRI;
          end
        end
        // Read states: first cycle presents the address, second captures data.
        S_KRI: begin
          r_ph <= ~r_ph;
          if (r_ph) begin
            r_si    <= s_rdata;
            r_j     <= r_j + s_rdata + w_kbyte;
            r_state <= S_KRJ;
          end
        end
        S_KRJ: begin
          r_ph <= ~r_ph;
          if (r_ph) begin
            r_sj    <= s_rdata;
            r_state <= S_KWI;
          end
        end
        S_KWI: r_state <= S_KWJ;
        S_KWJ: begin
          r_kidx <= (r_kidx == 2'd2) ? 2'd0 : r_kidx + 2'd1;
          if (r_i == 8'hFF) begin
            r_i     <= 8'd1;
            r_j     <= 8'd0;
            r_k     <= '0;
            r_state <= S_PRI;
          end else begin
            r_i     <= r_i + 8'd1;
            r_state <= S_KRI;
          end
        end
        S_PRI: begin
          r_ph <= ~r_ph;
          if (r_ph) begin
            r_si    <= s_rdata;
            r_j     <= r_j + s_rdata;
            r_state <= S_PRJ;
          end
        end
        S_PRJ: begin
          r_ph <= ~r_ph;
          if (r_ph) begin
            r_sj    <= s_rdata;
            r_state <= S_PWI;
          end
        end
        S_PWI: r_state <= S_PWJ;
        S_PWJ: r_state <= S_PRF;
        S_PRF: begin
          r_ph <= ~r_ph;
          if (r_ph) begin
            r_d     <= s_rdata ^ rom_rdata;
            r_state <= S_PWD;
          end
        end
        S_PWD: begin
          r_bad <= w_bad;
          if (w_last) begin
            r_finish <= 1'b1;
            r_valid  <= ~w_bad;
            r_busy   <= 1'b0;
            r_state  <= S_DONE;
          end else begin
            r_k     <= r_k + 1'b1;
            r_i     <= r_i + 8'd1;
            r_state <= S_PRI;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rc4_key_tester.md
Name: rc4_key_tester

Overview:
- Decrypt/test engine on the far end of the brute-force handshake: receives a candidate key and a one-cycle restart pulse, and answers with finish_decrypt and valid.
- Runs full RC4 (S init, KSA, PRGA) on a 3-byte key against an encrypted-message ROM.
- Writes plaintext to a result RAM and checks every byte is lowercase a-z (0x61..0x7A) or space (0x20).
- Sits between the key-search controller and the three on-chip memories: S RAM 256x8, message ROM, result RAM.

Parameters:
- MSG_LEN, 32, message length in bytes (1..2**MSG_AW).
- MSG_AW, 5, address width of message ROM and result RAM.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- restart  in  1  one-cycle pulse; abort any run and start a new one with key_in
- key_in  in  24  candidate key; key byte0=[23:16], byte1=[15:8], byte2=[7:0]; the 22-bit search counter is zero-extended at top level
- finish_decrypt  out  1  level; run complete, result held
- valid  out  1  level; meaningful only while finish_decrypt=1
- busy  out  1  run in progress
- s_addr  out  8  S RAM address
- s_wdata  out  8  S RAM write data
- s_wren  out  1  S RAM write enable
- s_rdata  in  8  S RAM read data, 1-cycle synchronous latency
- rom_addr  out  MSG_AW  message ROM address
- rom_rdata  in  8  ROM data, 1-cycle latency
- d_addr  out  MSG_AW  result RAM address
- d_wdata  out  8  result RAM write data
- d_wren  out  1  result RAM write enable

Behaviour:
- Reset values:
  - Outputs: finish_decrypt=0, valid=0, busy=0, all wren=0, all addresses/data 0.
  - State: LOAD_KEY.
  - The block auto-starts after reset; no restart pulse is needed for the first key.
- LOAD_KEY:
  - Registers key_in; busy=1.
  - Next state INIT.
- restart=1 in any state:
  - At that edge: finish_decrypt<=0, valid<=0, wren<=0, state<=LOAD_KEY.
  - Restart takes priority over every other transition, including DONE.
  - Handshake rule: the controller samples finish_decrypt in the cycle after it drops restart, so the clear happens on the same edge restart is seen.
- INIT:
  - S[k]=k for k=0..255, one write per cycle: exactly 256 cycles.
- KSA:
  - j=0; for i=0..255: read S[i], j=(j+S[i]+key[i mod 3]) mod 256, read S[j], write S[i]<=S[j], write S[j]<=old S[i].
  - States: KSA_RD_I, KSA_RD_J, KSA_WR_I, KSA_WR_J. Each read state holds its address for the latency cycle.
  - i mod 3 is a 2-bit wrapping counter, not a divider.
  - The swap is correct when i==j: the second write stores the same value.
- PRGA:
  - i=j=0; for k=0..MSG_LEN-1:
    - i=i+1; read S[i]; j=j+S[i]; read S[j]; swap.
    - f=S[(S[i]+S[j]) mod 256]; read rom[k].
    - d[k]<=f^rom[k].
  - All index sums are 8-bit wrap-around; k uses an MSG_AW-bit counter that stops at MSG_LEN-1.
- Character check: each plaintext byte is tested as it is written; a failure latches an internal bad flag.
- DONE:
  - finish_decrypt=1, valid=!bad, busy=0, all wren=0.
  - Held until restart or rst.
- Only one memory write per cycle per RAM; no read and write to S RAM in the same cycle.
- rst mid-run: immediate abort, reset values, auto-restart with the current key_in.

Optional Feature:
- Macro: RC4_EARLY_ABORT_EN.
- Defined:
  - On the first invalid plaintext byte, that byte is still written to d.
  - The next cycle enters DONE with valid=0, skipping the remaining PRGA iterations.
- Undefined:
  - All MSG_LEN bytes are always decrypted and written.
  - valid is reported only at the end.

Test Plan:
- Reset, then restart with key_in=0x000000: during INIT, the bench monitors S writes -> s_addr/s_wdata run 0x00..0xFF over 256 consecutive cycles with s_wren=1.
- MSG_LEN=9, key_in=0x4B6579 ("Key"), ROM=BB F3 16 E8 D9 40 AF 0A D3:
  - Without the macro: d = 50 6C 61 69 6E 74 65 78 74 ("Plaintext"), finish_decrypt=1, valid=0 (0x50 fails the check).
  - With RC4_EARLY_ABORT_EN: only d[0]=0x50 is written, then finish_decrypt=1, valid=0.
- MSG_LEN=32, ROM built by a software model as keystream(key 0x000102) XOR "the quick brown fox jumps over a" -> d matches that string, finish_decrypt=1, valid=1.
- Same ROM, key_in=0x000103 -> finish_decrypt=1, valid=0; d matches the software model byte-for-byte.
- Restart pulse issued mid-KSA (e.g. cycle 400 after start) with a new key_in -> finish_decrypt stays 0; the run restarts from INIT (s_addr=0x00 write two cycles later); the final result matches a clean run of the new key.
- Full loop with the key-search controller, init_val=0x000100, correct key 0x000102 -> controller skips 0x000100, reaches 0x000102, solved=1; finish_decrypt is never seen high at START with a stale result.
